// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one uart_tx between NUM_REQ
// byte-stream requesters. A grant covers a whole packet and is released on
// the packet's last byte, after MAX_BURST bytes, or after a GAP_LIMIT idle gap.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16,
  parameter int GAP_LIMIT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 active,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [7:0]  BURST_MAX = 8'(MAX_BURST);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_LIMIT - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   gidx;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   cand;
  logic            pick_found;
  logic [7:0]      burst_cnt;
  logic [15:0]     gap_cnt;
  logic            last_q;
  logic            sel_valid;
  logic            sel_last;
  logic [7:0]      sel_data;
  logic            accept;

  // Round-robin search: first valid requester strictly after ptr, with wrap.
  // Scanning from the far end lets the closest candidate overwrite the rest.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IW'((int'(ptr) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Granted requester's lane, and the handshake that moves one byte.
  always_comb begin
    sel_valid = req_valid[gidx];
    sel_last  = req_last[gidx];
    sel_data  = req_data[{gidx, 3'b000} +: 8];
    req_ready = (state == SEND && !tx_busy) ? grant : '0;
    accept    = (state == SEND) && !tx_busy && sel_valid;
  end

  // Arbitration FSM: grant, byte handoff to uart_tx, and packet release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= IW'(NUM_REQ - 1);
      gidx      <= '0;
      grant     <= '0;
      active    <= 1'b0;
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      burst_cnt <= 8'h00;
      gap_cnt   <= 16'h0000;
      last_q    <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (!tx_busy && pick_found) begin
            grant     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
            gidx      <= pick_idx;
            active    <= 1'b1;
            burst_cnt <= 8'h00;
            gap_cnt   <= 16'h0000;
            state     <= SEND;
          end
        end
        SEND: begin
          if (accept) begin
            tx_data  <= sel_data;
            tx_start <= 1'b1;
            last_q   <= sel_last;
            if (burst_cnt < BURST_MAX)
              burst_cnt <= burst_cnt + 8'h01;
            gap_cnt  <= 16'h0000;
            state    <= WAIT_BUSY;
          end else if (!sel_valid) begin
            if (gap_cnt == GAP_LAST) begin
              ptr    <= gidx;
              grant  <= '0;
              active <= 1'b0;
              state  <= IDLE;
            end else begin
              gap_cnt <= gap_cnt + 16'h0001;
            end
          end
        end
        WAIT_BUSY: begin
          if (tx_busy)
            state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (last_q || burst_cnt == BURST_MAX) begin
              ptr    <= gidx;
              grant  <= '0;
              active <= 1'b0;
              state  <= IDLE;
            end else begin
              state <= SEND;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester byte queues feed the DUT, a small
// uart_tx model answers tx_start with a busy window, and a monitor checks each
// emitted byte against a hand-ordered expectation queue.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int FRAME   = 10;

  logic                 clk;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   grant;
  logic                 active;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;

  logic [8:0]  rq [NUM_REQ][$];
  logic [11:0] exp_q [$];
  logic [NUM_REQ-1:0] last_hs;
  logic        prev_start;
  int          busy_left;
  int          tests;
  int          fails;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .MAX_BURST(4), .GAP_LIMIT(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant), .active(active),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges beyond the bounded waits
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    tests++;
    fails++;
    $display("[TB] FAIL %s: got timeout, expected event", name);
  endtask

  task automatic applyStimulus(input int r, input logic [7:0] d, input logic last);
    rq[r].push_back({last, d});
  endtask

  task automatic expectByte(input int r, input logic [7:0] d);
    logic [3:0] g;
    g = 4'b0001 << r;
    exp_q.push_back({g, d});
  endtask

  // uart_tx model: samples tx_start at the edge, raises busy just after it
  initial begin
    tx_busy   = 1'b0;
    busy_left = 0;
    forever begin
      @(posedge clk);
      if (tx_start) begin
        #1;
        busy_left = FRAME;
        tx_busy   = 1'b1;
      end else begin
        #1;
        if (busy_left > 1) begin
          busy_left = busy_left - 1;
        end else begin
          busy_left = 0;
          tx_busy   = 1'b0;
        end
      end
    end
  end

  // Requester driver: present queue heads, pop after a sampled handshake
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    last_hs   = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++)
        if (last_hs[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rq[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_data[i*8 +: 8] = rq[i][0][7:0];
          req_last[i]        = rq[i][0][8];
        end else begin
          req_valid[i]       = 1'b0;
          req_data[i*8 +: 8] = 8'h00;
          req_last[i]        = 1'b0;
        end
      end
      #4;
      last_hs = req_valid & req_ready;
    end
  end

  // Monitor: scoreboard pop on each tx_start plus per-cycle protocol checks
  initial begin
    logic [11:0] e;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        checkOutput("start_single", {31'd0, prev_start}, 32'd0);
        checkOutput("start_not_busy", {31'd0, tx_busy}, 32'd0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_start: got byte 0x%0h grant 0x%0h, expected none", tx_data, grant);
        end else begin
          e = exp_q.pop_front();
          checkOutput("tx_data", {24'd0, tx_data}, {24'd0, e[7:0]});
          checkOutput("start_grant", {28'd0, grant}, {28'd0, e[11:8]});
        end
      end
      if (tx_start || (|last_hs))
        checkOutput("start_follows_accept", {31'd0, tx_start}, {31'd0, |last_hs});
      checkOutput("ready_in_grant", {28'd0, req_ready & ~grant}, 32'd0);
      prev_start = tx_start;
    end
  end

  task automatic waitGrant(input logic [3:0] g);
    int n;
    n = 0;
    while (!(grant == g && tx_busy) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) timeoutFail("wait_grant");
  endtask

  task automatic waitIdle(input string name);
    int  n;
    logic pend;
    n = 0;
    forever begin
      @(negedge clk);
      pend = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() > 0) pend = 1'b1;
      if (!pend && exp_q.size() == 0 && grant == '0 && !tx_busy && !tx_start) break;
      n++;
      if (n >= 3000) begin
        timeoutFail(name);
        exp_q.delete();
        break;
      end
    end
    repeat (2) @(negedge clk);
    checkOutput({name, "_grant"}, {28'd0, grant}, 32'd0);
    checkOutput({name, "_active"}, {31'd0, active}, 32'd0);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Directed scenarios
  initial begin
    int n;
    int hold;
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_tx_start", {31'd0, tx_start}, 32'd0);
    checkOutput("rst_tx_data", {24'd0, tx_data}, 32'd0);
    checkOutput("rst_grant", {28'd0, grant}, 32'd0);
    checkOutput("rst_active", {31'd0, active}, 32'd0);
    checkOutput("rst_ready", {28'd0, req_ready}, 32'd0);
    rst = 1'b0;

    // Single byte from requester 0
    applyStimulus(0, 8'hA5, 1'b1);
    expectByte(0, 8'hA5);
    waitIdle("t1_idle");

    // Packet from requester 1; requester 0 shows up mid-packet and must wait
    applyStimulus(1, 8'h11, 1'b0);
    applyStimulus(1, 8'h22, 1'b0);
    applyStimulus(1, 8'h33, 1'b1);
    expectByte(1, 8'h11);
    expectByte(1, 8'h22);
    expectByte(1, 8'h33);
    expectByte(0, 8'h44);
    waitGrant(4'b0010);
    applyStimulus(0, 8'h44, 1'b1);
    waitIdle("t2_idle");

    // Everyone busy with one-byte packets after a fresh reset
    pulseReset();
    applyStimulus(0, 8'h30, 1'b1);
    applyStimulus(1, 8'h31, 1'b1);
    applyStimulus(2, 8'h32, 1'b1);
    applyStimulus(3, 8'h33, 1'b1);
    applyStimulus(0, 8'h34, 1'b1);
    applyStimulus(1, 8'h35, 1'b1);
    expectByte(0, 8'h30);
    expectByte(1, 8'h31);
    expectByte(2, 8'h32);
    expectByte(3, 8'h33);
    expectByte(0, 8'h34);
    expectByte(1, 8'h35);
    waitIdle("t3_idle");

    // Burst limit of 4 splits requester 2's stream around requester 3
    for (int i = 0; i < 6; i++) applyStimulus(2, 8'(8'h40 + i), (i == 5));
    applyStimulus(3, 8'h50, 1'b1);
    for (int i = 0; i < 4; i++) expectByte(2, 8'(8'h40 + i));
    expectByte(3, 8'h50);
    expectByte(2, 8'h44);
    expectByte(2, 8'h45);
    waitIdle("t4_idle");

    // Gap timeout: requester 0 stalls mid-packet, requester 1 takes over
    applyStimulus(0, 8'h60, 1'b0);
    applyStimulus(1, 8'h61, 1'b1);
    expectByte(0, 8'h60);
    expectByte(1, 8'h61);
    waitGrant(4'b0001);
    n = 0;
    while (tx_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeoutFail("t5_busy_fall");
    hold = 0;
    while (grant == 4'b0001 && hold < 100) begin
      hold++;
      @(negedge clk);
    end
    checkOutput("t5_gap_hold", 32'(hold), 32'd9);
    waitIdle("t5_idle");

    // Reset while the first byte of a 3-byte packet is inside uart_tx
    applyStimulus(2, 8'h70, 1'b0);
    applyStimulus(2, 8'h71, 1'b0);
    applyStimulus(2, 8'h72, 1'b1);
    applyStimulus(0, 8'h80, 1'b1);
    expectByte(2, 8'h70);
    expectByte(0, 8'h80);
    expectByte(2, 8'h71);
    expectByte(2, 8'h72);
    waitGrant(4'b0100);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_grant", {28'd0, grant}, 32'd0);
    checkOutput("t6_rst_active", {31'd0, active}, 32'd0);
    checkOutput("t6_rst_tx_data", {24'd0, tx_data}, 32'd0);
    checkOutput("t6_rst_tx_start", {31'd0, tx_start}, 32'd0);
    checkOutput("t6_rst_ready", {28'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    waitIdle("t6_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
